// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with sticky request capture.
// Grants one index at a time on a valid/ready handshake, in either fixed
// priority (highest index wins) or round-robin order, and drives an
// active-low 7-segment digit showing the granted index.
module prio_encoder_rr #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [N-1:0]     req_i,
  input  logic             mode_i,
  input  logic             clear_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic [7:0]       seg_o
);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e           state;
  logic [N-1:0]     pending;
  logic [IDX_W-1:0] last_grant;

  logic             fire;
  logic [N-1:0]     fire_mask;
  logic [N-1:0]     new_req;
  logic [N-1:0]     eff;
  logic             eff_any;
  logic [IDX_W-1:0] rr_base;
  logic [N-1:0]     below;
  logic [IDX_W-1:0] sel_fixed;
  logic [IDX_W-1:0] sel_below;
  logic [IDX_W-1:0] sel_rr;
  logic [IDX_W-1:0] sel;
  logic [3:0]       digit;

  // Highest set index of a request vector; zero when the vector is empty.
  function automatic logic [IDX_W-1:0] highest(input logic [N-1:0] vec);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) res = IDX_W'(i);
    end
    return res;
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex digit, dp off.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign fire    = valid_o & ready_i;
  assign new_req = en_i ? req_i : '0;

  // The granted bit leaves the pending set on fire; a fresh request for the
  // same bit in that cycle is OR-ed back in afterwards, so set wins.
  assign fire_mask = fire ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
  assign eff       = (pending & ~fire_mask) | new_req;
  assign eff_any   = |eff;

  // Round-robin pointer: the grant being retired this edge, else the last one.
  assign rr_base = fire ? idx_o : last_grant;

  // Split eff at the round-robin pointer: indices strictly below it come first
  // (searched downward), then the search wraps to N-1 and continues downward.
  always_comb begin
    below = '0;
    for (int unsigned i = 0; i < N; i++) begin
      below[i] = eff[i] && (IDX_W'(i) < rr_base);
    end
  end

  assign sel_fixed = highest(eff);
  assign sel_below = highest(below);
  assign sel_rr    = (|below) ? sel_below : sel_fixed;
  assign sel       = mode_i ? sel_rr : sel_fixed;

  // Grant state machine with registered valid/index and pending capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      valid_o    <= 1'b0;
      idx_o      <= '0;
      last_grant <= '0;
      pending    <= '0;
    end else if (clear_i) begin
      // Drop the outstanding grant and all accumulated requests; the index
      // and round-robin pointer are kept.
      state   <= StIdle;
      valid_o <= 1'b0;
      pending <= '0;
    end else begin
      pending <= eff;
      case (state)
        StIdle: begin
          if (eff_any) begin
            idx_o   <= sel;
            valid_o <= 1'b1;
            state   <= StGrant;
          end
        end
        StGrant: begin
          // Without fire the grant is held and new requests only accumulate.
          if (fire) begin
            last_grant <= idx_o;
            if (eff_any) begin
              idx_o <= sel;
            end else begin
              valid_o <= 1'b0;
              state   <= StIdle;
            end
          end
        end
        default: begin
          valid_o <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

  assign any_o = |pending;
  assign digit = 4'(idx_o);

  // Segment output follows the registered grant directly, blank when idle.
  always_comb begin
    seg_o = 8'hFF;
    if (valid_o) seg_o = seg_decode(digit);
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: an 8-input and a 16-input instance share all
// control stimulus. A queue-based reference model predicts each cycle's
// outputs and the ordered grant stream; a monitor checks both at negedge.
module tb_prio_encoder_rr;

  logic        clk = 1'b0;
  logic        rst, en, mode, clr, rdy;
  logic [15:0] req;

  logic       v0, a0, v1, a1;
  logic [2:0] i0;
  logic [3:0] i1;
  logic [7:0] s0, s1;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .IDX_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req[7:0]), .mode_i(mode), .clear_i(clr),
    .ready_i(rdy), .valid_o(v0), .idx_o(i0), .any_o(a0), .seg_o(s0)
  );

  prio_encoder_rr #(.N(16), .IDX_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .mode_i(mode), .clear_i(clr),
    .ready_i(rdy), .valid_o(v1), .idx_o(i1), .any_o(a1), .seg_o(s1)
  );

  typedef struct {
    bit       valid;
    int       idx;
    bit       any;
    bit [7:0] seg;
  } obs_t;

  typedef struct {
    bit [15:0] pend;
    int        cur;
    int        last;
    bit        busy;
  } model_t;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  model_t m [2];
  obs_t   exp_q0[$], exp_q1[$];
  int     grant_q0[$], grant_q1[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  // Next request to serve: fixed = highest index; round-robin = walk downward
  // from p-1 with wraparound, by modular arithmetic over the index ring.
  function automatic int pick(bit [15:0] r, int n, bit rr, int p);
    if (!rr) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int d = 1; d <= n; d++) begin
        int c;
        c = (p - d + n) % n;
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic push_grant(input int u, input int g);
    if (u == 0) grant_q0.push_back(g);
    else        grant_q1.push_back(g);
  endtask

  task automatic drop_grant(input int u);
    if (u == 0 && grant_q0.size() > 0) void'(grant_q0.pop_back());
    if (u == 1 && grant_q1.size() > 0) void'(grant_q1.pop_back());
  endtask

  // Advance the reference model of instance u across one clock edge.
  task automatic model_edge(input int u, input int n);
    bit [15:0] live;
    bit        fire;
    int        p, g;
    obs_t      o;
    if (rst) begin
      if (m[u].busy) drop_grant(u);
      m[u].pend = '0; m[u].cur = 0; m[u].last = 0; m[u].busy = 1'b0;
    end else if (clr) begin
      if (m[u].busy) drop_grant(u);
      m[u].pend = '0; m[u].busy = 1'b0;
    end else begin
      fire = m[u].busy && rdy;
      live = m[u].pend;
      if (fire) live[m[u].cur] = 1'b0;
      if (en) live = live | (req & ((n == 16) ? 16'hFFFF : 16'h00FF));
      p = fire ? m[u].cur : m[u].last;
      if (fire) m[u].last = m[u].cur;
      m[u].pend = live;
      if (!m[u].busy || fire) begin
        g = pick(live, n, mode, p);
        if (g >= 0) begin
          m[u].cur  = g;
          m[u].busy = 1'b1;
          push_grant(u, g);
        end else begin
          m[u].busy = 1'b0;
        end
      end
    end
    o.valid = m[u].busy;
    o.idx   = m[u].cur;
    o.any   = |m[u].pend;
    o.seg   = m[u].busy ? seg_tab[m[u].cur] : 8'hFF;
    if (u == 0) exp_q0.push_back(o);
    else        exp_q1.push_back(o);
  endtask

  task automatic setin(input bit r, input bit e, input bit [15:0] q, input bit md,
                       input bit c, input bit rd);
    rst = r; en = e; req = q; mode = md; clr = c; rdy = rd;
  endtask

  // One clock: inputs already set; model follows the edge, then step past it.
  task automatic step();
    @(posedge clk);
    model_edge(0, 8);
    model_edge(1, 16);
    #1;
  endtask

  // Monitor: per-cycle output compare and in-order grant scoreboard.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      chk("d8 valid", 16'(v0), 16'(e.valid));
      chk("d8 idx",   16'(i0), 16'(e.idx));
      chk("d8 any",   16'(a0), 16'(e.any));
      chk("d8 seg",   16'(s0), 16'(e.seg));
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      chk("d16 valid", 16'(v1), 16'(e.valid));
      chk("d16 idx",   16'(i1), 16'(e.idx));
      chk("d16 any",   16'(a1), 16'(e.any));
      chk("d16 seg",   16'(s1), 16'(e.seg));
    end
    if (v0 === 1'b1 && rdy && !rst && !clr) begin
      if (grant_q0.size() == 0) chk("d8 unexpected fire", 16'(i0), 16'hFFFF);
      else                      chk("d8 grant order", 16'(i0), 16'(grant_q0.pop_front()));
    end
    if (v1 === 1'b1 && rdy && !rst && !clr) begin
      if (grant_q1.size() == 0) chk("d16 unexpected fire", 16'(i1), 16'hFFFF);
      else                      chk("d16 grant order", 16'(i1), 16'(grant_q1.pop_front()));
    end
  end

  initial begin
    // Reset
    setin(1, 0, 16'h0, 0, 0, 0);
    step();
    step();
    chk("rst valid", 16'(v0), 16'h0);
    chk("rst any", 16'(a0), 16'h0);
    chk("rst seg", 16'(s0), 16'hFF);

    // Fixed priority drain of 1010_0100: 7, 5, 2, then idle
    setin(0, 1, 16'h00A4, 0, 0, 1);
    step();
    chk("tp1 idx7", 16'(i0), 16'd7);
    chk("tp1 seg7", 16'(s0), 16'hF8);
    setin(0, 0, 16'h0, 0, 0, 1);
    step();
    chk("tp1 idx5", 16'(i0), 16'd5);
    chk("tp1 seg5", 16'(s0), 16'h92);
    step();
    chk("tp1 idx2", 16'(i0), 16'd2);
    chk("tp1 seg2", 16'(s0), 16'hA4);
    step();
    chk("tp1 idle valid", 16'(v0), 16'h0);
    chk("tp1 idle any", 16'(a0), 16'h0);
    chk("tp1 idle seg", 16'(s0), 16'hFF);

    // Backpressure: grant 5 held while bit 7 pulses
    setin(0, 1, 16'h0020, 0, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      setin(0, 1, (k % 2 == 0) ? 16'h0080 : 16'h0000, 0, 0, 0);
      step();
      chk("bp hold idx", 16'(i0), 16'd5);
      chk("bp hold seg", 16'(s0), 16'h92);
    end
    setin(0, 0, 16'h0, 0, 0, 1);
    step();
    chk("bp next idx7", 16'(i0), 16'd7);
    step();
    chk("bp drained", 16'(v0), 16'h0);

    // Round-robin fairness, then fixed priority under the same load
    setin(1, 0, 16'h0, 0, 0, 0);
    step();
    setin(0, 1, 16'hFFFF, 1, 0, 1);
    for (int k = 0; k < 18; k++) begin
      step();
      chk("rr order", 16'(i0), 16'(7 - (k % 8)));
    end
    setin(0, 1, 16'hFFFF, 0, 0, 1);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fixed starves", 16'(i0), 16'd7);
    end
    setin(0, 0, 16'h0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step();

    // Set-over-clear on the firing bit
    setin(0, 1, 16'h0008, 0, 0, 0);
    step();
    setin(0, 1, 16'h0008, 0, 0, 1);
    step();
    chk("soc regrant idx", 16'(i0), 16'd3);
    chk("soc any", 16'(a0), 16'h1);
    chk("soc valid", 16'(v0), 16'h1);
    setin(0, 0, 16'h0, 0, 0, 1);
    step();
    chk("soc done", 16'(v0), 16'h0);

    // Clear during grant
    setin(0, 1, 16'h000F, 0, 0, 0);
    step();
    setin(0, 0, 16'h0, 0, 1, 0);
    step();
    chk("clr valid", 16'(v0), 16'h0);
    chk("clr any", 16'(a0), 16'h0);
    chk("clr seg", 16'(s0), 16'hFF);
    setin(0, 1, 16'h0002, 0, 0, 0);
    step();
    chk("clr next idx", 16'(i0), 16'd1);
    chk("clr next seg", 16'(s0), 16'hF9);
    setin(0, 0, 16'h0, 0, 0, 1);
    step();

    // Wide instance: bit 12 only exists on the 16-input encoder
    setin(0, 1, 16'h1000, 0, 0, 0);
    step();
    chk("n16 idx12", 16'(i1), 16'd12);
    chk("n16 seg C", 16'(s1), 16'hC6);
    chk("n8 ignores bit12", 16'(v0), 16'h0);
    setin(0, 1, 16'h00F0, 0, 0, 0);
    step();
    setin(1, 1, 16'h00F0, 0, 0, 0);
    step();
    chk("midrst v8", 16'(v0), 16'h0);
    chk("midrst i8", 16'(i0), 16'h0);
    chk("midrst a8", 16'(a0), 16'h0);
    chk("midrst s8", 16'(s0), 16'hFF);
    chk("midrst v16", 16'(v1), 16'h0);
    chk("midrst i16", 16'(i1), 16'h0);
    chk("midrst a16", 16'(a1), 16'h0);
    chk("midrst s16", 16'(s1), 16'hFF);

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      setin(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
            16'($urandom & $urandom), ($urandom_range(0, 3) == 0) ? ~mode : mode,
            ($urandom_range(0, 23) == 0), ($urandom_range(0, 3) != 0));
      step();
    end

    // Drain and confirm every predicted grant was observed
    setin(0, 0, 16'h0, 0, 0, 1);
    for (int k = 0; k < 24; k++) step();
    @(negedge clk);
    #1;
    chk("d8 grants left", 16'(grant_q0.size()), 16'h0);
    chk("d16 grants left", 16'(grant_q1.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
